// File: rtl/commit_trace_buffer_pkg.sv
// Shared retire-port and trace-entry types for the commit trace buffer.
package commit_trace_buffer_pkg;

    localparam int TRACE_SEQ_W  = 64;
    localparam int TRACE_DROP_W = 16;

    typedef struct packed {
        logic        valid_commit;
        logic        flushed;
        logic [31:0] pc;
        logic [5:0]  pdst;
        logic        valid_write;
        logic [31:0] data;
    } writeback_toARF;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [31:0]            pc;
        logic [5:0]             pdst;
        logic                   wr;
        logic [31:0]            data;
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Two-write / one-read circular buffer holding trace entries; write 1 lands
// in the slot after write 0.
module commit_trace_fifo
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we0,
    input  logic         i_we1,
    input  trace_entry_t i_d0,
    input  trace_entry_t i_d1,
    input  logic         i_pop,
    output logic [CW-1:0] o_count,
    output trace_entry_t o_head
);

    trace_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_we0) r_mem[r_wptr] <= i_d0;
        if (i_we1) r_mem[r_wptr + AW'(1)] <= i_d1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_we0) + AW'(i_we1);
            r_rptr  <= r_rptr + AW'(i_pop);
            r_count <= r_count + CW'(i_we0) + CW'(i_we1) - CW'(i_pop);
        end
    end

    // Gating keeps the output at zero while empty, including right after reset.
    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-side trace buffer: sequence tagging, overflow accounting and an
// optional fetch-PC watchdog enabled by COMMIT_TRACE_WATCHDOG_EN.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HANG_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  writeback_toARF          commit_0_i,
    input  writeback_toARF          commit_1_i,
    input  logic [31:0]             current_pc_i,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output trace_entry_t            trace_o,
    output logic [TRACE_DROP_W-1:0] drop_count_o,
    output logic                    overflow_o,
    output logic                    hang_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [TRACE_SEQ_W-1:0]  r_seq;
    logic [TRACE_DROP_W-1:0] r_drop_count;
    logic                    r_overflow;

    logic          w_live0, w_live1, w_pop, w_we0, w_we1;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_free;
    logic [1:0]    w_nlive, w_ndrop;
    logic [TRACE_DROP_W:0] w_drop_sum;
    trace_entry_t  w_d0, w_d1;

    assign w_live0 = commit_0_i.valid_commit & ~commit_0_i.flushed;
    assign w_live1 = w_live0 & commit_1_i.valid_commit & ~commit_1_i.flushed;

    assign trace_valid_o = (w_count != '0);
    assign w_pop         = trace_valid_o & trace_ready_i;

    // A same-cycle pop frees a slot for a same-cycle push.
    assign w_free = (CW+1)'(DEPTH) - {1'b0, w_count} + (CW+1)'(w_pop);
    assign w_we0  = w_live0 & (w_free != '0);
    assign w_we1  = w_live1 & (w_free >= (CW+1)'(2));

    assign w_nlive    = {1'b0, w_live0} + {1'b0, w_live1};
    assign w_ndrop    = {1'b0, w_live0 & ~w_we0} + {1'b0, w_live1 & ~w_we1};
    assign w_drop_sum = {1'b0, r_drop_count} + (TRACE_DROP_W+1)'(w_ndrop);

    assign w_d0 = '{seq: r_seq, pc: commit_0_i.pc, pdst: commit_0_i.pdst,
                    wr: commit_0_i.valid_write, data: commit_0_i.data};
    assign w_d1 = '{seq: r_seq + TRACE_SEQ_W'(1), pc: commit_1_i.pc,
                    pdst: commit_1_i.pdst, wr: commit_1_i.valid_write,
                    data: commit_1_i.data};

    commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_we0   (w_we0),
        .i_we1   (w_we1),
        .i_d0    (w_d0),
        .i_d1    (w_d1),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (trace_o)
    );

    // Dropped commits still consume sequence numbers so gaps expose drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq        <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_seq        <= r_seq + TRACE_SEQ_W'(w_nlive);
            r_drop_count <= w_drop_sum[TRACE_DROP_W] ? '1
                                                     : w_drop_sum[TRACE_DROP_W-1:0];
            r_overflow   <= r_overflow | (w_ndrop != 2'd0);
        end
    end

    assign drop_count_o = r_drop_count;
    assign overflow_o   = r_overflow;

`ifdef COMMIT_TRACE_WATCHDOG_EN
    logic [31:0] r_old_pc;
    logic [31:0] r_hang_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_old_pc   <= '0;
            r_hang_cnt <= '0;
        end else if (current_pc_i != r_old_pc) begin
            r_old_pc   <= current_pc_i;
            r_hang_cnt <= '0;
        end else if (r_hang_cnt != '1) begin
            r_hang_cnt <= r_hang_cnt + 32'd1;
        end
    end

    assign hang_o = (r_hang_cnt >= 32'(HANG_CYCLES));
`else
    logic w_unused_pc;
    assign w_unused_pc = ^{current_pc_i, 32'(HANG_CYCLES)};
    assign hang_o      = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int HANG  = 500;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    writeback_toARF c0 = '0;
    writeback_toARF c1 = '0;
    logic [31:0]    cur_pc = '0;
    logic           ready = 1'b0;
    logic           trace_valid;
    trace_entry_t   trace;
    logic [15:0]    drop_count;
    logic           overflow;
    logic           hang;

    int checks = 0;
    int errors = 0;

    commit_trace_buffer #(.DEPTH(DEPTH), .HANG_CYCLES(HANG)) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_0_i    (c0),
        .commit_1_i    (c1),
        .current_pc_i  (cur_pc),
        .trace_valid_o (trace_valid),
        .trace_ready_i (ready),
        .trace_o       (trace),
        .drop_count_o  (drop_count),
        .overflow_o    (overflow),
        .hang_o        (hang)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model
    trace_entry_t m_q[$];
    logic [63:0]  m_seq;
    int           m_drop;
    logic         m_ovf;
    logic [31:0]  m_last_pc;
    longint       m_edges, m_chg;

    function automatic trace_entry_t mk(input writeback_toARF c, input logic [63:0] s);
        trace_entry_t e;
        e.seq = s; e.pc = c.pc; e.pdst = c.pdst; e.wr = c.valid_write; e.data = c.data;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_seq = 0; m_drop = 0; m_ovf = 0;
            m_last_pc = 0; m_chg = m_edges;
        end else begin
            int nlive, free, room;
            trace_entry_t e0, e1;
            e0 = mk(c0, m_seq);
            e1 = mk(c1, m_seq + 64'd1);
            nlive = 0;
            if (c0.valid_commit && !c0.flushed) begin
                nlive = 1;
                if (c1.valid_commit && !c1.flushed) nlive = 2;
            end
            if (m_q.size() != 0 && ready) void'(m_q.pop_front());
            free = DEPTH - m_q.size();
            room = (nlive < free) ? nlive : free;
            if (room >= 1) m_q.push_back(e0);
            if (room >= 2) m_q.push_back(e1);
            if (nlive > room) begin
                m_drop = m_drop + (nlive - room);
                if (m_drop > 16'hFFFF) m_drop = 16'hFFFF;
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 64'(nlive);
            m_edges++;
            if (cur_pc != m_last_pc) begin
                m_last_pc = cur_pc;
                m_chg = m_edges;
            end
        end
    end

    // Per-cycle compare and capture of accepted entries
    trace_entry_t got[$];
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", trace_valid, 0);
            chk("rst_trace", trace, 0);
            chk("rst_drop", drop_count, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_hang", hang, 0);
        end else begin
            chk("valid", trace_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("head", trace, m_q[0]);
            chk("drop_count", drop_count, 16'(m_drop));
            chk("overflow", overflow, m_ovf);
`ifdef COMMIT_TRACE_WATCHDOG_EN
            chk("hang", hang, (m_edges - m_chg) >= HANG);
`else
            chk("hang", hang, 0);
`endif
            if (trace_valid && ready) got.push_back(trace);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v0, input logic f0, input logic [31:0] pc0,
                       input logic [31:0] d0, input logic v1, input logic f1,
                       input logic [31:0] pc1, input logic rdy);
        c0 = '{valid_commit: v0, flushed: f0, pc: pc0, pdst: pc0[7:2],
               valid_write: pc0[2], data: d0};
        c1 = '{valid_commit: v1, flushed: f1, pc: pc1, pdst: pc1[7:2],
               valid_write: pc1[2], data: d0 + 32'd1};
        ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drv(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        idle(0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle(1);
        n = 0;
        while (trace_valid && n < 20) begin
            step();
            n++;
        end
        chk("drain_timeout", trace_valid, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        // Single commit
        drv(1, 0, 32'h100, 32'hDEAD, 0, 0, 0, 1);
        step();
        idle(1);
        chk("t1_valid", trace_valid, 1);
        chk("t1_seq", trace.seq, 0);
        chk("t1_pc", trace.pc, 32'h100);
        chk("t1_data", trace.data, 32'hDEAD);
        step();
        chk("t1_empty", trace_valid, 0);

        // Dual commits at full rate, single-entry drain
        do_reset();
        got.delete();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'h200, 32'h10 + 32'(i), 1, 0, 32'h204, 1);
            step();
        end
        drain();
        chk("t2_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) begin
            chk("t2_seq", got[i].seq, 64'(i));
            chk("t2_pc", got[i].pc, (i % 2) ? 32'h204 : 32'h200);
        end
        chk("t2_nodrop", drop_count, 0);

        // Flush combinations
        do_reset();
        drv(1, 1, 32'h300, 32'h1, 1, 0, 32'h304, 1);
        step();
        idle(1);
        chk("t3_p1_only", trace_valid, 0);
        drv(1, 0, 32'h308, 32'h2, 1, 1, 32'h30C, 0);
        step();
        idle(0);
        chk("t3_p0_valid", trace_valid, 1);
        chk("t3_p0_seq", trace.seq, 0);
        chk("t3_p0_pc", trace.pc, 32'h308);
        step();
        chk("t3_hold_pc", trace.pc, 32'h308);
        drain();

        // Overflow with consumer stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 32'h400 + 32'(8 * i), 32'h20, 1, 0, 32'h404 + 32'(8 * i), 0);
            step();
        end
        idle(0);
        chk("t4_drop", drop_count, 2);
        chk("t4_ovf", overflow, 1);
        got.delete();
        drain();
        drv(1, 0, 32'h500, 32'h30, 0, 0, 0, 1);
        step();
        drain();
        chk("t4_kept", got.size(), 9);
        if (got.size() == 9) begin
            chk("t4_last_kept", got[7].seq, 7);
            chk("t4_next_seq", got[8].seq, 10);
        end

        // Full FIFO with pop and dual push in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'h600, 32'h40, 1, 0, 32'h604, 0);
            step();
        end
        chk("t5_nodrop_yet", drop_count, 0);
        drv(1, 0, 32'h700, 32'h50, 1, 0, 32'h704, 1);
        step();
        idle(0);
        chk("t5_drop", drop_count, 1);
        chk("t5_ovf", overflow, 1);
        drain();

        // Watchdog
        do_reset();
        cur_pc = 32'h80;
        step();
        repeat (HANG - 1) step();
        chk("t6_before", hang, 0);
        step();
`ifdef COMMIT_TRACE_WATCHDOG_EN
        chk("t6_hang", hang, 1);
`else
        chk("t6_hang", hang, 0);
`endif
        repeat (3) step();
        cur_pc = 32'h84;
        step();
        chk("t6_clear", hang, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
